ahb3lite_cmd_master: RTL and testbench

- Single-transfer AHB3-lite master driven by a simple valid/ready command channel and a valid/ready response channel.
- It is the initiator counterpart to the SoC's AHB slaves (RAM, ROM, APB bridge, zslave).
- It lets a host-side agent (UART/SPI debug link, test sequencer) read and write any AHB slave.
- It connects to one master port of the generated AHB3-lite interconnect.

---
 rtl/ahb3lite_pkg.sv | 20 ++
 rtl/ahb3lite_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_ahb3lite_cmd_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings and the command-master state type.
// Imported by the command master and any other AHB-side blocks.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } cmd_state_t;

endpackage

// File: rtl/ahb3lite_cmd_master.sv
// Single-transfer AHB3-lite master fed by a valid/ready command channel.
// Returns each result on a valid/ready response channel, one transfer at a time.
import ahb3lite_pkg::*;

module ahb3lite_cmd_master #(
  parameter int         HADDR_SIZE = 32,
  parameter int         HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,

  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HWRITE,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HRESP,
  input  logic                  HREADY
);

  function automatic logic [HDATA_SIZE-1:0] lane_rep(
    input logic [HDATA_SIZE-1:0] d,
    input logic [2:0]            sz
  );
    logic [HDATA_SIZE-1:0] r;
    r = d;
    if (sz == HSIZE_BYTE)  r = {4{d[7:0]}};
    if (sz == HSIZE_HWORD) r = {2{d[15:0]}};
    return r;
  endfunction

  function automatic logic [HDATA_SIZE-1:0] lane_ext(
    input logic [HDATA_SIZE-1:0] d,
    input logic [1:0]            a,
    input logic [2:0]            sz
  );
    logic [HDATA_SIZE-1:0] r;
    r = d;
    if (sz == HSIZE_BYTE) begin
      r = '0;
      r[7:0] = d[{a, 3'b000} +: 8];
    end
    if (sz == HSIZE_HWORD) begin
      r = '0;
      r[15:0] = a[1] ? d[31:16] : d[15:0];
    end
    return r;
  endfunction

  cmd_state_t            state_q, state_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic [2:0]            hsize_q, hsize_d;
  logic                  hwrite_q, hwrite_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  legal;

  // Held low through reset so nothing is accepted while the bus is down.
  assign cmd_ready = HRESETn
                   && (state_q == IDLE)
                   && !rsp_valid_q;

  assign legal =
      (cmd_size == HSIZE_BYTE)
    | ((cmd_size == HSIZE_HWORD) & ~cmd_addr[0])
    | ((cmd_size == HSIZE_WORD) & (cmd_addr[1:0] == 2'b00));

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (legal) begin
            state_d  = ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            if (cmd_write)
              hwdata_d = lane_rep(cmd_wdata, cmd_size);
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          state_d  = DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      DATA: begin
        // First ERROR cycle has HREADY low and is simply waited out.
        if (HREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (!hwrite_q && !HRESP)
                      ? lane_ext(HRDATA, haddr_q[1:0], hsize_q)
                      : '0;
        end
      end
      default: begin
        state_d  = IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Directed bench for ahb3lite_cmd_master; the bench plays the AHB slave.
// Drives after each rising edge, samples 1ns later.
module tb_ahb3lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = 3'd0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic [31:0] HRDATA = 32'h0;
  logic        HRESP = 1'b0;
  logic        HREADY = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  ahb3lite_cmd_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_size  (cmd_size),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWRITE    (HWRITE),
    .HMASTLOCK (HMASTLOCK),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .HREADY    (HREADY)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Present one command for a single edge; returns in cycle N+1.
  task automatic issue(input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    chk("cmd_ready_pre", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_size  = s;
    cmd_addr  = a;
    cmd_wdata = wd;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Zero-wait transfer; returns in cycle N+3.
  task automatic xfer(input logic w, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd);
    issue(w, s, a, wd);
    tick;
    HRDATA = rd;
    tick;
    HRDATA = 32'h0;
  endtask

  task automatic rsp_chk(input string t, input logic err,
                         input logic [31:0] rd);
    chk({t, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({t, "_err"}, {31'b0, rsp_err}, {31'b0, err});
    chk({t, "_rdata"}, rsp_rdata, rd);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({t, "_drop"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_rspv", {31'b0, rsp_valid}, 32'd0);
    chk("hburst", {29'b0, HBURST}, 32'd0);
    chk("hprot", {28'b0, HPROT}, 32'h3);
    chk("hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    HRESETn = 1'b1;
    tick;

    // Zero-wait word write
    issue(1'b1, 3'd2, 32'h2000_0010, 32'hDEAD_BEEF);
    chk("w_nonseq", {30'b0, HTRANS}, 32'd2);
    chk("w_haddr", HADDR, 32'h2000_0010);
    chk("w_hwrite", {31'b0, HWRITE}, 32'd1);
    chk("w_hsize", {29'b0, HSIZE}, 32'd2);
    tick;
    chk("w_idle", {30'b0, HTRANS}, 32'd0);
    chk("w_hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("w_rsp_early", {31'b0, rsp_valid}, 32'd0);
    tick;
    rsp_chk("w", 1'b0, 32'h0);
    chk("w_ready_post", {31'b0, cmd_ready}, 32'd1);

    // Read with 2 address and 3 data wait states
    HRDATA = 32'hBAD0_BAD0;
    issue(1'b0, 3'd2, 32'h2000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      HREADY = (i == 2);
      chk("rw_nonseq", {30'b0, HTRANS}, 32'd2);
      chk("rw_haddr", HADDR, 32'h2000_0010);
      chk("rw_hwrite", {31'b0, HWRITE}, 32'd0);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      HREADY = (i == 3);
      if (i == 3) HRDATA = 32'hCAFE_F00D;
      chk("rw_data_idle", {30'b0, HTRANS}, 32'd0);
      chk("rw_rsp_early", {31'b0, rsp_valid}, 32'd0);
      tick;
    end
    HRDATA = 32'h0;
    rsp_chk("rw", 1'b0, 32'hCAFE_F00D);

    // Lane extraction and replication
    xfer(1'b0, 3'd0, 32'h2000_0013, 32'h0, 32'h1122_3344);
    rsp_chk("rb3", 1'b0, 32'h0000_0011);
    xfer(1'b0, 3'd0, 32'h2000_0010, 32'h0, 32'h1122_3344);
    rsp_chk("rb0", 1'b0, 32'h0000_0044);
    xfer(1'b0, 3'd1, 32'h2000_0012, 32'h0, 32'h1122_3344);
    rsp_chk("rh2", 1'b0, 32'h0000_1122);
    xfer(1'b0, 3'd1, 32'h2000_0010, 32'h0, 32'h1122_3344);
    rsp_chk("rh0", 1'b0, 32'h0000_3344);
    issue(1'b1, 3'd0, 32'h2000_0001, 32'hFFFF_FFA5);
    chk("wb_hsize", {29'b0, HSIZE}, 32'd0);
    tick;
    chk("wb_hwdata", HWDATA, 32'hA5A5_A5A5);
    tick;
    rsp_chk("wb", 1'b0, 32'h0);
    issue(1'b1, 3'd1, 32'h2000_0002, 32'hABCD_1234);
    tick;
    chk("wh_hwdata", HWDATA, 32'h1234_1234);
    tick;
    rsp_chk("wh", 1'b0, 32'h0);

    // Two-cycle ERROR response
    issue(1'b0, 3'd2, 32'hF000_0000, 32'h0);
    chk("e_nonseq", {30'b0, HTRANS}, 32'd2);
    tick;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    HRDATA = 32'h1234_5678;
    chk("e_idle1", {30'b0, HTRANS}, 32'd0);
    tick;
    HREADY = 1'b1;
    chk("e_idle2", {30'b0, HTRANS}, 32'd0);
    chk("e_rsp_early", {31'b0, rsp_valid}, 32'd0);
    tick;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    rsp_chk("e", 1'b1, 32'h0);
    xfer(1'b0, 3'd2, 32'h2000_0010, 32'h0, 32'h5A5A_0001);
    rsp_chk("e_after", 1'b0, 32'h5A5A_0001);

    // Illegal commands
    issue(1'b0, 3'd2, 32'h2000_0002, 32'h0);
    chk("ill_w_htrans", {30'b0, HTRANS}, 32'd0);
    rsp_chk("ill_w", 1'b1, 32'h0);
    issue(1'b1, 3'd3, 32'h2000_0000, 32'h0);
    chk("ill_s_htrans", {30'b0, HTRANS}, 32'd0);
    rsp_chk("ill_s", 1'b1, 32'h0);
    issue(1'b0, 3'd1, 32'h2000_0001, 32'h0);
    chk("ill_h_htrans", {30'b0, HTRANS}, 32'd0);
    rsp_chk("ill_h", 1'b1, 32'h0);

    // Response backpressure with a command waiting
    xfer(1'b0, 3'd2, 32'h2000_0020, 32'h0, 32'h0BAD_C0DE);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_size  = 3'd2;
    cmd_addr  = 32'h2000_0030;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h0BAD_C0DE);
      chk("bp_htrans", {30'b0, HTRANS}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("bp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("bp_htrans_after", {30'b0, HTRANS}, 32'd0);

    // Reset during a DATA wait state
    issue(1'b1, 3'd2, 32'h2000_0040, 32'h7777_8888);
    tick;
    HREADY = 1'b0;
    tick;
    chk("rd_hwdata", HWDATA, 32'h7777_8888);
    #1 HRESETn = 1'b0;
    #1;
    chk("rd_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rd_haddr", HADDR, 32'h0);
    chk("rd_hwdata0", HWDATA, 32'h0);
    chk("rd_rspv", {31'b0, rsp_valid}, 32'd0);
    chk("rd_ready", {31'b0, cmd_ready}, 32'd0);
    HREADY = 1'b1;
    tick;
    HRESETn = 1'b1;
    tick;
    chk("rd_ready_post", {31'b0, cmd_ready}, 32'd1);
    chk("rd_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Reset during the address phase
    issue(1'b0, 3'd2, 32'h2000_0050, 32'h0);
    chk("ra_nonseq", {30'b0, HTRANS}, 32'd2);
    #1 HRESETn = 1'b0;
    #1;
    chk("ra_htrans", {30'b0, HTRANS}, 32'd0);
    tick;
    HRESETn = 1'b1;
    tick;
    xfer(1'b0, 3'd0, 32'h2000_0052, 32'h0, 32'h00AB_0000);
    rsp_chk("post_rst", 1'b0, 32'h0000_00AB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
